// File: rtl/sad_multi_acc.sv
// Multi-candidate SAD accumulator. One template pixel stream is compared with NUM_CAND
// search-window streams at once. Each channel keeps a saturating sum of absolute
// differences over BLK_PIX pixels. A sequential scan then picks the minimum SAD and the
// index of its channel.
module sad_multi_acc #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned BLK_PIX  = 256,
    parameter int unsigned SAD_W    = 16,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned CNT_W    = 9
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      start_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [PIX_W-1:0]          pel_tb_i,
    input  logic [NUM_CAND*PIX_W-1:0] pel_sw_i,
    output logic [NUM_CAND*SAD_W-1:0] sad_all_o,
    output logic [SAD_W-1:0]          sad_min_o,
    output logic [IDX_W-1:0]          min_idx_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned SumW = ((SAD_W > PIX_W) ? SAD_W : PIX_W) + 1;
    localparam logic [SumW-1:0] SatMax = SumW'({SAD_W{1'b1}});

    typedef enum logic [2:0] {StIdle, StAccum, StDrain, StScan, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PIX_W-1:0] tb_q;
    logic [PIX_W-1:0] sw_q    [NUM_CAND];
    logic [SAD_W-1:0] acc_q   [NUM_CAND];
    logic             vld_q;
    logic [IDX_W-1:0] scan_q;
    logic [SAD_W-1:0] sad_min_q;
    logic [IDX_W-1:0] min_idx_q;
    logic             fin_q;
    logic             done_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [PIX_W-1:0] diff_w  [NUM_CAND];
    logic [SumW-1:0]  sum_w   [NUM_CAND];
    logic [SAD_W-1:0] acc_add [NUM_CAND];
    logic [SAD_W-1:0] cur_sad;
    logic             accept;
    logic             blk_start;
    logic             last_beat;

    assign accept    = (state_q == StAccum) && in_valid_i;
    assign blk_start = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign last_beat = accept && (cnt_q == CNT_W'(BLK_PIX - 1));

    // Per-channel absolute difference and saturating accumulate of the staged beat.
    always_comb begin
        for (int i = 0; i < NUM_CAND; i++) begin
            diff_w[i]  = (sw_q[i] >= tb_q) ? (sw_q[i] - tb_q) : (tb_q - sw_q[i]);
            sum_w[i]   = SumW'(acc_q[i]) + SumW'(diff_w[i]);
            acc_add[i] = (sum_w[i] > SatMax) ? {SAD_W{1'b1}} : sum_w[i][SAD_W-1:0];
        end
    end

    // Select the accumulator addressed by the scan index.
    always_comb begin
        cur_sad = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (scan_q == IDX_W'(i)) begin
                cur_sad = acc_q[i];
            end
        end
    end

    // Datapath: capture stage on accept, accumulate stage one edge later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tb_q  <= '0;
            vld_q <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                sw_q[i]  <= '0;
                acc_q[i] <= '0;
            end
        end else if (clr_i || blk_start) begin
            cnt_q <= '0;
            tb_q  <= '0;
            vld_q <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                sw_q[i]  <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            vld_q <= accept;
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                tb_q  <= pel_tb_i;
                for (int i = 0; i < NUM_CAND; i++) begin
                    sw_q[i] <= pel_sw_i[i*PIX_W +: PIX_W];
                end
            end
            if (vld_q) begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    acc_q[i] <= acc_add[i];
                end
            end
        end
    end

    // Control FSM with minimum scan; all status outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            scan_q     <= '0;
            sad_min_q  <= '0;
            min_idx_q  <= '0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (clr_i) begin
            state_q    <= StIdle;
            scan_q     <= '0;
            sad_min_q  <= '0;
            min_idx_q  <= '0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // The done pulse trails the final scan compare by one edge.
            fin_q  <= 1'b0;
            done_q <= fin_q;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q    <= StAccum;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StAccum: begin
                    if (last_beat) begin
                        state_q    <= StDrain;
                        in_ready_q <= 1'b0;
                    end
                end
                StDrain: begin
                    state_q <= StScan;
                    scan_q  <= '0;
                end
                StScan: begin
                    // Strict compare keeps the lowest index on ties.
                    if ((scan_q == '0) || (cur_sad < sad_min_q)) begin
                        sad_min_q <= cur_sad;
                        min_idx_q <= scan_q;
                    end
                    if (scan_q == IDX_W'(NUM_CAND - 1)) begin
                        state_q <= StDone;
                        fin_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_sad_out
        assign sad_all_o[g*SAD_W +: SAD_W] = acc_q[g];
    end

    assign sad_min_o  = sad_min_q;
    assign min_idx_o  = min_idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign in_ready_o = in_ready_q;

endmodule

// File: tb/tb_sad_multi_acc.sv
// Directed bench for sad_multi_acc: main instance (SAD_W=16) plus a narrow SAD_W=9
// instance for saturation. Inputs change 1 time unit after the rising edge and outputs
// are sampled at that point.
module tb_sad_multi_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, start, in_valid, in_ready;
    logic [7:0]  pel_tb;
    logic [31:0] pel_sw;
    logic [63:0] sad_all;
    logic [15:0] sad_min;
    logic [1:0]  min_idx;
    logic        busy, done;

    logic        s_clr, s_start, s_valid, s_ready;
    logic [7:0]  s_tb;
    logic [31:0] s_sw;
    logic [35:0] s_sad_all;
    logic [8:0]  s_sad_min;
    logic [1:0]  s_min_idx;
    logic        s_busy, s_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  bt_tb [4];
    logic [31:0] bt_sw [4];

    always #5 clk = ~clk;

    sad_multi_acc #(
        .PIX_W(8), .NUM_CAND(4), .BLK_PIX(4), .SAD_W(16), .IDX_W(2), .CNT_W(9)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .pel_tb_i(pel_tb), .pel_sw_i(pel_sw),
        .sad_all_o(sad_all), .sad_min_o(sad_min), .min_idx_o(min_idx),
        .busy_o(busy), .done_o(done)
    );

    sad_multi_acc #(
        .PIX_W(8), .NUM_CAND(4), .BLK_PIX(4), .SAD_W(9), .IDX_W(2), .CNT_W(9)
    ) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(s_clr), .start_i(s_start),
        .in_valid_i(s_valid), .in_ready_o(s_ready), .pel_tb_i(s_tb), .pel_sw_i(s_sw),
        .sad_all_o(s_sad_all), .sad_min_o(s_sad_min), .min_idx_o(s_min_idx),
        .busy_o(s_busy), .done_o(s_done)
    );

    task automatic set_basic();
        for (int b = 0; b < 4; b++) begin
            bt_tb[b] = 8'd10;
            bt_sw[b] = {8'd200, 8'd10, 8'd7, 8'd12};
        end
    endtask

    // ch0,ch2 total 50; ch1,ch3 total 20.
    task automatic set_tie();
        for (int b = 0; b < 4; b++) bt_tb[b] = 8'd100;
        bt_sw[0] = {8'd95, 8'd88, 8'd105, 8'd112};
        bt_sw[1] = {8'd95, 8'd88, 8'd105, 8'd112};
        bt_sw[2] = {8'd95, 8'd87, 8'd105, 8'd113};
        bt_sw[3] = {8'd95, 8'd87, 8'd105, 8'd113};
    endtask

    // Drives one block; lat = edges from last accept to done (-1 on timeout).
    task automatic run_block(input int gap, input int start_beat, input bit do_start,
                             output int lat, output int rdy_err);
        lat = -1;
        rdy_err = 0;
        if (do_start) begin
            start = 1'b1; @(posedge clk); #1; start = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            if (b == start_beat) begin
                start = 1'b1; in_valid = 1'b0; @(posedge clk); #1; start = 1'b0;
            end
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                if (in_ready !== 1'b1) rdy_err++;
                @(posedge clk); #1;
            end
            in_valid = 1'b1; pel_tb = bt_tb[b]; pel_sw = bt_sw[b];
            if (in_ready !== 1'b1) rdy_err++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (in_ready !== 1'b0) rdy_err++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; in_valid = 1'b0; pel_tb = '0; pel_sw = '0;
        s_clr = 1'b0; s_start = 1'b0; s_valid = 1'b0; s_tb = '0; s_sw = '0;
        #12;
        n_tests++;
        if ({sad_all, sad_min, min_idx} !== '0) begin
            n_fail++; $display("FAIL reset_results: got %h %h %h want 0", sad_all, sad_min, min_idx);
        end
        n_tests++;
        if ({busy, done, in_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got busy/done/rdy=%b%b%b want 000", busy, done, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int lat, re;
        set_basic();
        run_block(0, -1, 1'b1, lat, re);
        n_tests++;
        if (sad_all !== {16'd760, 16'd0, 16'd12, 16'd8}) begin
            n_fail++; $display("FAIL single_sad_all: got %h want 02f8000000 0c0008", sad_all);
        end
        n_tests++;
        if (sad_min !== 16'd0 || min_idx !== 2'd2) begin
            n_fail++; $display("FAIL single_min: got %0d idx %0d want 0 idx 2", sad_min, min_idx);
        end
        n_tests++;
        if (lat !== 6) begin
            n_fail++; $display("FAIL single_latency: got %0d want 6", lat);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_busy_done: got %b want 0", busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL single_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_tie();
        int lat, re;
        set_tie();
        run_block(0, -1, 1'b1, lat, re);
        n_tests++;
        if (sad_all !== {16'd20, 16'd50, 16'd20, 16'd50}) begin
            n_fail++; $display("FAIL tie_sad_all: got %h want 20/50/20/50", sad_all);
        end
        n_tests++;
        if (sad_min !== 16'd20 || min_idx !== 2'd1) begin
            n_fail++; $display("FAIL tie_min: got %0d idx %0d want 20 idx 1", sad_min, min_idx);
        end
    endtask

    task automatic test_gaps();
        int lat, re;
        set_basic();
        run_block(2, -1, 1'b1, lat, re);
        n_tests++;
        if (sad_all !== {16'd760, 16'd0, 16'd12, 16'd8} || sad_min !== 16'd0 ||
            min_idx !== 2'd2) begin
            n_fail++; $display("FAIL gaps_result: got %h min %0d idx %0d", sad_all, sad_min, min_idx);
        end
        n_tests++;
        if (re !== 0) begin
            n_fail++; $display("FAIL gaps_in_ready: got %0d bad cycles want 0", re);
        end
        n_tests++;
        if (lat !== 6) begin
            n_fail++; $display("FAIL gaps_latency: got %0d want 6", lat);
        end
    endtask

    task automatic test_saturation();
        bit seen = 1'b0;
        s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_valid = 1'b1; s_tb = 8'd0; s_sw = {8'd0, 8'd0, 8'd0, 8'd255};
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (s_done === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (s_sad_all[8:0] !== 9'd511) begin
            n_fail++; $display("FAIL sat_ch0: got %0d want 511", s_sad_all[8:0]);
        end
        n_tests++;
        if (s_sad_min !== 9'd0 || s_min_idx !== 2'd1 || !seen) begin
            n_fail++; $display("FAIL sat_min: got %0d idx %0d done %b want 0 idx 1 done 1",
                               s_sad_min, s_min_idx, seen);
        end
    endtask

    task automatic test_clr();
        int lat, re;
        bit seen = 1'b0;
        set_basic();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; pel_tb = bt_tb[b]; pel_sw = bt_sw[b];
            @(posedge clk); #1;
        end
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL clr_flags: got busy %b rdy %b want 0 0", busy, in_ready);
        end
        n_tests++;
        if (sad_all !== '0 || sad_min !== '0 || min_idx !== '0) begin
            n_fail++; $display("FAIL clr_zero: got %h %0d %0d want 0", sad_all, sad_min, min_idx);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL clr_idle: got done/busy activity want none");
        end
        run_block(0, -1, 1'b1, lat, re);
        n_tests++;
        if (sad_all !== {16'd760, 16'd0, 16'd12, 16'd8} || min_idx !== 2'd2 || lat !== 6) begin
            n_fail++; $display("FAIL clr_after: got %h idx %0d lat %0d", sad_all, min_idx, lat);
        end
    endtask

    task automatic test_ignored_start();
        int lat, re;
        set_basic();
        run_block(0, 2, 1'b1, lat, re);
        n_tests++;
        if (sad_all !== {16'd760, 16'd0, 16'd12, 16'd8} || lat !== 6) begin
            n_fail++; $display("FAIL ign_start: got %h lat %0d want 02f8..0c0008 lat 6", sad_all, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, re;
        set_basic();
        run_block(0, -1, 1'b1, lat, re);
        // Start during the done pulse cycle.
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || min_idx !== 2'd2 || sad_min !== 16'd0) begin
            n_fail++; $display("FAIL b2b_hold: got busy %b rdy %b idx %0d min %0d want 1 1 2 0",
                               busy, in_ready, min_idx, sad_min);
        end
        set_tie();
        run_block(0, -1, 1'b0, lat, re);
        n_tests++;
        if (sad_min !== 16'd20 || min_idx !== 2'd1 || lat !== 6) begin
            n_fail++; $display("FAIL b2b_result: got %0d idx %0d lat %0d want 20 idx 1 lat 6",
                               sad_min, min_idx, lat);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen = 1'b0;
        set_tie();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; pel_tb = bt_tb[b]; pel_sw = bt_sw[b];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_tests++;
        if (busy !== 1'b1 || sad_min !== 16'd20) begin
            n_fail++; $display("FAIL rst_pre_scan: got busy %b min %0d want 1 20", busy, sad_min);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sad_all, sad_min, min_idx, busy, done, in_ready} !== '0) begin
            n_fail++; $display("FAIL rst_mid_scan: got %h %0d %0d %b%b%b want all 0",
                               sad_all, sad_min, min_idx, busy, done, in_ready);
        end
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL rst_no_done: got done pulse want none");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_gaps();
        test_saturation();
        test_clr();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sad_multi_acc.md
Name: sad_multi_acc

Overview:
- Parametrised successor of the single-channel SAD element.
- One template-block pixel stream is compared against NUM_CAND search-window pixel streams in parallel.
- Each channel accumulates a sum of absolute differences over a block of BLK_PIX pixels. A sequential scan then selects the minimum SAD and its candidate index.
- Sits between the search-window/template buffers and the motion-vector decision logic.

Parameters:
- PIX_W, 8: pixel width in bits.
- NUM_CAND, 4: number of parallel candidate channels (≥1).
- BLK_PIX, 256: pixels accumulated per block (≥1).
- SAD_W, 16: accumulator width. Saturates at all-ones if too narrow.
- IDX_W, 2: candidate index width. Must satisfy 2^IDX_W ≥ NUM_CAND.
- CNT_W, 9: pixel counter width. Must satisfy 2^CNT_W > BLK_PIX.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort/clear; highest priority after reset.
- start  in  1  begin a new block; honoured only in IDLE or DONE.
- in_valid  in  1  pel_tb/pel_sw valid this cycle.
- in_ready  out  1  block accepts pixels (high only in ACCUM).
- pel_tb  in  PIX_W  template pixel.
- pel_sw  in  NUM_CAND*PIX_W  candidate pixels; channel i at bits [i*PIX_W +: PIX_W].
- sad_all  out  NUM_CAND*SAD_W  per-channel accumulators, same packing.
- sad_min  out  SAD_W  minimum SAD of the last completed block.
- min_idx  out  IDX_W  channel index of sad_min.
- busy  out  1  high in ACCUM, DRAIN, SCAN.
- done  out  1  one-cycle pulse when sad_min/min_idx become valid.

Behaviour:
- Reset (rst_n low, async): state IDLE.
  - All accumulators, pixel registers, counter, sad_min and min_idx are 0.
  - done=0, busy=0, in_ready=0.
- States: IDLE, ACCUM, DRAIN, SCAN, DONE. All outputs are registered.
- IDLE/DONE + start: at the edge, clear all accumulators, pixel registers and counter; go to ACCUM. sad_min/min_idx hold until overwritten by the scan.
- ACCUM:
  - in_ready=1. A beat is accepted on an edge with in_valid=1; at that edge the pixels are captured into stage registers and the counter increments.
  - Stage 2: on the edge after capture, each channel adds |sw_reg[i] - tb_reg| (PIX_W bits, zero-extended) to its accumulator.
  - When the accepted beat makes count == BLK_PIX, go to DRAIN. in_ready drops the cycle after that edge.
  - Gaps (in_valid=0) add nothing.
- DRAIN: one cycle. Performs the final add, then goes to SCAN with scan index 0.
- SCAN: NUM_CAND cycles; one channel compared per edge.
  - Index 0 loads sad_min/min_idx unconditionally.
  - For index i>0, sad_min/min_idx update only when sad[i] < sad_min (strict), so ties keep the lowest index.
  - After index NUM_CAND-1, go to DONE.
- DONE: done=1 for exactly the first cycle only. The state holds with done=0 afterwards; results are held.
- Latency: done is high in the cycle beginning NUM_CAND+2 edges after the edge accepting the last beat.
- Saturation: an accumulator that would exceed 2^SAD_W-1 sticks at 2^SAD_W-1.
- start in ACCUM/DRAIN/SCAN is ignored.
- clr (any state): at the edge, go to IDLE and zero everything as in reset, except done=0. clr overrides simultaneous start and in_valid.
- start together with the done pulse cycle (state DONE) is legal. The new block begins, and the results of the previous block remain on sad_min/min_idx until the new SCAN.
- Async reset mid-block aborts immediately; no partial result is reported.
- sad_all is live; it is meaningful only from SCAN onward.

Test Plan:
1. Single channel check (NUM_CAND=4, BLK_PIX=4, SAD_W=16).
   - Stimulus: pel_tb=10 for all beats; channels = 12/7/10/200 for all beats.
   - Required: sad_all = {760,0,12,8} (channel 3 down to channel 0), sad_min=0, min_idx=2.
   - Required: done exactly 6 edges after the last accept.
2. Tie-break.
   - Stimulus: channels 1 and 3 both give SAD 20; channels 0 and 2 give 50.
   - Required: min_idx=1, sad_min=20.
3. Back-pressure gaps.
   - Stimulus: the same 4 beats as test 1, spaced by in_valid=0 cycles.
   - Required: identical results to test 1; in_ready=1 throughout ACCUM, 0 after the 4th accept.
4. Saturation.
   - Stimulus: SAD_W=9, BLK_PIX=4, tb=0, sw=255 on channel 0.
   - Required: sad_all channel 0 = 511 (not 1020 mod 512).
5. clr mid-ACCUM.
   - Stimulus: assert clr after 2 beats.
   - Required: next cycle state IDLE, busy=0, sad_all=0, no done. A following start with a fresh block gives correct results.
6. Reset and ignored start.
   - Stimulus: pulse rst_n low during SCAN.
   - Required: all outputs 0 immediately, no done.
   - Stimulus: start during ACCUM.
   - Required: no effect on the count or accumulators.
